// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares the write port of the UART TX FIFO
//   between N_REQ producers. The winner owns the port for a whole burst, so
//   the words of one message are never interleaved with another producer's.
//   Writes are paced from the FIFO occupancy so the FIFO cannot overflow.
//
// Ports
//   clk, rst_n     system clock, asynchronous active-low reset
//   req_valid      per-requester word valid
//   req_last       per-requester last word of the current burst
//   req_data       packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready      per-requester accept (combinational, owner only)
//   req_enable     register-controlled requester enable mask
//   fifo_count     current FIFO occupancy
//   fifo_wr_en     registered one-cycle FIFO write strobe
//   fifo_data      registered FIFO write data (holds between writes)
//   grant          one-hot current owner, 0 when idle
//   busy           high while a burst owns the port
//   force_release  one-cycle pulse on timeout, MAX_BURST or disable release
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_DEPTH   = 32,
  parameter int CNT_WIDTH    = 6,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ-1:0]            req_enable,
  input  logic [CNT_WIDTH-1:0]        fifo_count,
  output logic                        fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic                        force_release
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int BEAT_W  = $clog2(MAX_BURST + 1);
  localparam int STALL_W = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state_q, state_d;
  // rr_q is both the round-robin pointer and, while in BURST, the owner.
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [BEAT_W-1:0]    beat_q, beat_d, beat_inc;
  logic [STALL_W-1:0]   stall_q, stall_d, stall_inc;
  logic                 wr_d, force_d;
  logic [DATA_WIDTH-1:0] data_d;

  logic [DATA_WIDTH-1:0] words [N_REQ];
  logic [N_REQ-1:0]     cand;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx, scan_idx;
  logic                 space, accept;
  logic                 own_valid, own_last, own_en;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // The registered write still in flight has not reached fifo_count yet,
  // so it is counted as occupied.
  assign space = (int'(fifo_count) + int'(fifo_wr_en)) < FIFO_DEPTH;

  assign own_valid = req_valid[rr_q];
  assign own_last  = req_last[rr_q];
  assign own_en    = req_enable[rr_q];
  assign busy      = (state_q == BURST);
  assign grant     = busy ? (N_REQ'(1) << rr_q) : '0;
  assign accept    = busy && own_valid && own_en && space;

  // Saturating increments: the counters never wrap.
  assign beat_inc  = (beat_q == BEAT_W'(MAX_BURST)) ? beat_q : beat_q + BEAT_W'(1);
  assign stall_inc = (stall_q == STALL_W'(IDLE_TIMEOUT)) ? stall_q : stall_q + STALL_W'(1);

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[rr_q] = space & own_en;
  end

  // Scan starts one past the previous owner, so the last winner has the
  // lowest priority in the next arbitration.
  assign cand = req_valid & req_enable;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_q;
    scan_idx   = rr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = IDX_W'((int'(rr_q) + k) % N_REQ);
      if (!pick_found && cand[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // NOTE: every signal driven here gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    wr_d    = 1'b0;
    data_d  = fifo_data;
    force_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BURST;
          rr_d    = pick_idx;
          beat_d  = '0;
          stall_d = '0;
        end
      end
      BURST: begin
        if (!own_en) begin
          // Disabled owner: leave at once, nothing accepted this cycle.
          state_d = IDLE;
          force_d = 1'b1;
        end else if (accept) begin
          wr_d    = 1'b1;
          data_d  = words[rr_q];
          beat_d  = beat_inc;
          stall_d = '0;
          if (own_last) begin
            state_d = IDLE;
          end else if (beat_inc == BEAT_W'(MAX_BURST)) begin
            state_d = IDLE;
            force_d = 1'b1;
          end
        end else if (!own_valid) begin
          // Only a silent owner stalls; FIFO backpressure holds the counter.
          stall_d = stall_inc;
          if (stall_inc == STALL_W'(IDLE_TIMEOUT)) begin
            state_d = IDLE;
            force_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_q          <= IDX_W'(N_REQ - 1);
      beat_q        <= '0;
      stall_q       <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_data     <= '0;
      force_release <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      beat_q        <= beat_d;
      stall_q       <= stall_d;
      fifo_wr_en    <= wr_d;
      fifo_data     <= data_d;
      force_release <= force_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int CW    = 6;
  localparam int MAXB  = 16;
  localparam int TO    = 8;
  localparam int VW    = N + 1 + N + 1 + 1 + DW;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid, req_last, req_ready, req_enable, grant;
  logic [N*DW-1:0] req_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_wr_en, busy, force_release;
  logic [DW-1:0] fifo_data;

  int compared   = 0;
  int mismatched = 0;

  // Producers: one queue of pending words per requester, plus a mute flag.
  word_t pq [N][$];
  bit    mute [N];

  // Reference model: owner is -1 when nobody holds the port.
  int            m_owner, m_ptr, m_beats, m_stall;
  bit            m_wr, m_force;
  logic [DW-1:0] m_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW),
    .MAX_BURST(MAXB), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .req_enable(req_enable), .fifo_count(fifo_count),
    .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .grant(grant),
    .busy(busy), .force_release(force_release)
  );

  function automatic logic [VW-1:0] obs_vec();
    return {grant, busy, req_ready, fifo_wr_en, force_release, fifo_data};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [N-1:0] g;
    logic [N-1:0] r;
    bit space;
    g = '0;
    r = '0;
    space = (int'(fifo_count) + int'(m_wr)) < DEPTH;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      r[m_owner] = req_enable[m_owner] & space;
    end
    return {g, (m_owner >= 0), r, m_wr, m_force, m_data};
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_beats = 0;
    m_stall = 0;
    m_wr    = 0;
    m_force = 0;
    m_data  = '0;
  endtask

  // One clock of the arbitration rules; returns the accepted requester or -1.
  task automatic model_clock(output int acc);
    bit space;
    int g;
    space   = (int'(fifo_count) + int'(m_wr)) < DEPTH;
    acc     = -1;
    m_wr    = 0;
    m_force = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (req_valid[idx] && req_enable[idx]) begin
          m_owner = idx;
          m_ptr   = idx;
          m_beats = 0;
          m_stall = 0;
          break;
        end
      end
    end else begin
      g = m_owner;
      if (!req_enable[g]) begin
        m_owner = -1;
        m_force = 1;
      end else if (req_valid[g] && space) begin
        acc     = g;
        m_wr    = 1;
        m_data  = pq[g][0].d;
        m_beats = m_beats + 1;
        m_stall = 0;
        if (req_last[g]) begin
          m_owner = -1;
        end else if (m_beats == MAXB) begin
          m_owner = -1;
          m_force = 1;
        end
      end else if (!req_valid[g]) begin
        if (m_stall < TO) m_stall = m_stall + 1;
        if (m_stall == TO) begin
          m_owner = -1;
          m_force = 1;
        end
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0 && !mute[i]) begin
        req_valid[i]            = 1'b1;
        req_data[i*DW +: DW]    = pq[i][0].d;
        req_last[i]             = pq[i][0].l;
      end else begin
        req_valid[i]            = 1'b0;
        req_data[i*DW +: DW]    = '0;
        req_last[i]             = 1'b0;
      end
    end
  endtask

  task automatic push_word(input int i, input logic [DW-1:0] d, input bit l);
    word_t w;
    w.d = d;
    w.l = l;
    pq[i].push_back(w);
  endtask

  // Advance one clock: model and producers step at the edge, outputs are
  // sampled 1 ns after the following falling edge.
  task automatic tick();
    int acc;
    @(posedge clk);
    model_clock(acc);
    if (acc >= 0) void'(pq[acc].pop_front());
    @(negedge clk);
    drive();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      mute[i] = 0;
    end
    req_enable = '1;
    fifo_count = '0;
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; req_enable = '0; fifo_count = '0;
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      mute[i] = 0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (obs_vec() !== VW'(0)) begin
      mismatched++;
      $display("FAIL reset_state: got %h want %h", obs_vec(), VW'(0));
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL reset_idle cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] wq[$];
    do_reset();
    push_word(0, 16'h0011, 0);
    push_word(0, 16'h0022, 0);
    push_word(0, 16'h0033, 1);
    drive();
    for (int c = 1; c <= 8; c++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL single cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        compared++;
        if (grant !== 4'b0001) begin
          mismatched++;
          $display("FAIL single_grant: got %b want 0001", grant);
        end
      end
      if (fifo_wr_en) wq.push_back(fifo_data);
    end
    compared++;
    if (wq.size() != 3 || wq[0] !== 16'h0011 || wq[1] !== 16'h0022 || wq[2] !== 16'h0033) begin
      mismatched++;
      $display("FAIL single_words: got %0d words want 3 (11,22,33)", wq.size());
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL single_done: busy got %b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int glog[$];
    int writes;
    logic [N-1:0] prev;
    int want [5] = '{0, 1, 2, 3, 0};
    do_reset();
    push_word(0, 16'h00A0, 1);
    push_word(0, 16'h00A1, 1);
    push_word(1, 16'h00B0, 1);
    push_word(2, 16'h00C0, 1);
    push_word(3, 16'h00D0, 1);
    drive();
    prev = '0;
    writes = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL rr cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (grant != 0 && prev == 0) glog.push_back(onehot_idx(grant));
      if (fifo_wr_en) writes++;
      prev = grant;
    end
    compared++;
    if (glog.size() != 5) begin
      mismatched++;
      $display("FAIL rr_grants: got %0d grants want 5", glog.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        compared++;
        if (glog[i] != want[i]) begin
          mismatched++;
          $display("FAIL rr_order[%0d]: got %0d want %0d", i, glog[i], want[i]);
        end
      end
    end
    compared++;
    if (writes != 5) begin
      mismatched++;
      $display("FAIL rr_writes: got %0d want 5", writes);
    end
  endtask

  task automatic test_backpressure();
    int writes, blocked_writes, blocked_ready, forces;
    do_reset();
    fifo_count = CW'(31);
    for (int i = 0; i < 4; i++) push_word(1, DW'(16'h0100 + i), i == 3);
    drive();
    writes = 0; blocked_writes = 0; blocked_ready = 0; forces = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL bp cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (fifo_wr_en) writes++;
      if (force_release) forces++;
      if (c >= 3 && c <= 8) begin
        if (fifo_wr_en) blocked_writes++;
        if (req_ready != 0) blocked_ready++;
      end
      if (c == 2) fifo_count = CW'(32);
      if (c == 8) fifo_count = CW'(28);
    end
    compared++;
    if (writes != 4 || blocked_writes != 0 || blocked_ready != 0 || forces != 0) begin
      mismatched++;
      $display("FAIL bp_totals: got w=%0d bw=%0d br=%0d f=%0d want 4 0 0 0",
               writes, blocked_writes, blocked_ready, forces);
    end
  endtask

  task automatic test_max_burst();
    int glog[$];
    int writes, writes_at_force, forces;
    logic [N-1:0] prev;
    int want [4] = '{2, 3, 0, 2};
    do_reset();
    for (int i = 0; i < 20; i++) push_word(2, DW'($urandom), 0);
    drive();
    prev = '0; writes = 0; writes_at_force = -1; forces = 0;
    for (int c = 1; c <= 45; c++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL maxb cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (grant != 0 && prev == 0) glog.push_back(onehot_idx(grant));
      if (fifo_wr_en) writes++;
      if (force_release) begin
        forces++;
        if (writes_at_force < 0) writes_at_force = writes;
      end
      prev = grant;
      if (c == 2) begin
        push_word(3, 16'h3333, 1);
        push_word(0, 16'h0000, 1);
        drive();
      end
    end
    compared++;
    if (writes_at_force != 16) begin
      mismatched++;
      $display("FAIL maxb_len: got %0d writes at release want 16", writes_at_force);
    end
    compared++;
    if (forces != 2) begin
      mismatched++;
      $display("FAIL maxb_forces: got %0d want 2", forces);
    end
    compared++;
    if (glog.size() < 4) begin
      mismatched++;
      $display("FAIL maxb_grants: got %0d grants want 4", glog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (glog[i] != want[i]) begin
          mismatched++;
          $display("FAIL maxb_order[%0d]: got %0d want %0d", i, glog[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int force_cyc, writes;
    do_reset();
    push_word(3, 16'h5A5A, 1);
    drive();
    force_cyc = -1; writes = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL tmo cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (force_release && force_cyc < 0) force_cyc = c;
      if (fifo_wr_en) writes++;
      if (c == 1) begin
        mute[3] = 1;
        drive();
      end
    end
    compared++;
    if (force_cyc != 9 || writes != 0) begin
      mismatched++;
      $display("FAIL tmo_release: got cyc %0d writes %0d want cyc 9 writes 0", force_cyc, writes);
    end
  endtask

  task automatic test_enable_drop();
    int force_cyc, writes;
    do_reset();
    for (int i = 0; i < 5; i++) push_word(3, DW'(16'h0300 + i), i == 4);
    drive();
    force_cyc = -1; writes = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL endrop cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (force_release && force_cyc < 0) force_cyc = c;
      if (fifo_wr_en) writes++;
      if (c == 3) begin
        req_enable[3] = 1'b0;
        #1;
        compared++;
        if (req_ready !== 4'b0000) begin
          mismatched++;
          $display("FAIL endrop_ready: got %b want 0000", req_ready);
        end
      end
    end
    compared++;
    if (force_cyc != 4 || writes != 2) begin
      mismatched++;
      $display("FAIL endrop_release: got cyc %0d writes %0d want cyc 4 writes 2", force_cyc, writes);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(1, DW'(16'h0700 + i), i == 3);
    drive();
    for (int c = 1; c <= 2; c++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL rstmid cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (obs_vec() !== VW'(0)) begin
      mismatched++;
      $display("FAIL rstmid_async: got %h want %h", obs_vec(), VW'(0));
    end
    push_word(0, 16'h0F0F, 1);
    drive();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL rstmid_after cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        compared++;
        if (grant !== 4'b0001) begin
          mismatched++;
          $display("FAIL rstmid_first: got %b want 0001", grant);
        end
      end
    end
  endtask

  task automatic test_random();
    int mute_t [N];
    int en_t [N];
    int len;
    bit with_last;
    do_reset();
    for (int i = 0; i < N; i++) begin
      mute_t[i] = 0;
      en_t[i]   = 0;
    end
    for (int c = 1; c <= 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() == 0 && $urandom_range(0, 9) == 0) begin
          len = $urandom_range(1, 20);
          with_last = ($urandom_range(0, 4) != 0);
          for (int k = 0; k < len; k++) push_word(i, DW'($urandom), with_last && (k == len - 1));
        end
        if (mute_t[i] > 0) mute_t[i]--;
        else if ($urandom_range(0, 49) == 0) mute_t[i] = $urandom_range(5, 12);
        mute[i] = (mute_t[i] > 0) || ($urandom_range(0, 6) == 0);
        if (en_t[i] > 0) en_t[i]--;
        else if ($urandom_range(0, 99) == 0) en_t[i] = $urandom_range(1, 6);
        req_enable[i] = (en_t[i] == 0);
      end
      fifo_count = CW'($urandom_range(26, 32));
      drive();
      tick();
      compared++;
      if (obs_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL random cyc%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_backpressure();
    test_max_burst();
    test_timeout();
    test_enable_drop();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
